// File: rtl/xx6812_decoder_pkg.sv
// Shared constants and types for the xx6812 receive path.
// The tick constants match the encoder so both ends agree on timing.
package xx6812_decoder_pkg;

    localparam int T0H             = 5;
    localparam int T1H             = 10;
    localparam int T_BIT           = 15;
    localparam int DEF_RESET_TICKS = 600;
    localparam int DEF_ONE_THRESH  = 8;
    localparam int DEF_MIN_HIGH    = 2;
    localparam int DEF_MAX_HIGH    = 20;
    localparam int DEF_INDEX_WIDTH = 10;

    localparam int PIXEL_W = 24;
    localparam int HIGH_CW = 5;
    localparam int LOW_CW  = 10;
    localparam int BIT_CW  = 5;

    typedef enum logic [1:0] {
        ST_RESYNC = 2'd0,
        ST_LOW    = 2'd1,
        ST_HIGH   = 2'd2
    } state_e;

endpackage

// File: rtl/xx6812_decoder_if.sv
// Serial input and decoded pixel outputs of the xx6812 decoder.
// The decoder uses the slave modport.
interface xx6812_decoder_if
    import xx6812_decoder_pkg::*;
#(
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH
) ();

    logic                   led_data_in;
    logic [PIXEL_W-1:0]     pixel_data;
    logic                   pixel_valid;
    logic [INDEX_WIDTH-1:0] pixel_index;
    logic                   frame_end;
    logic                   protocol_error;

    modport master (
        output led_data_in,
        input  pixel_data, pixel_valid, pixel_index, frame_end, protocol_error
    );

    modport slave (
        input  led_data_in,
        output pixel_data, pixel_valid, pixel_index, frame_end, protocol_error
    );

endinterface

// File: rtl/xx6812_decoder_din_synchronizer.sv
// Two-flop synchronizer for the LED data line plus a delayed copy
// used to derive single-cycle rise/fall strobes.
module xx6812_decoder_din_synchronizer (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic din_s,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign din_s = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/xx6812_decoder.sv
// xx6812 line decoder: classifies high pulses into bits, assembles 24-bit
// pixels MSB-first and detects the low reset gap that closes a frame.
//
//  state  | meaning
//  RESYNC | lost or not yet locked; waiting for a full low gap
//  LOW    | line low between bits; watching for the next rise or a gap
//  HIGH   | measuring a high pulse; its width decides the bit value
module xx6812_decoder
    import xx6812_decoder_pkg::*;
#(
    parameter int INDEX_WIDTH   = DEF_INDEX_WIDTH,
    parameter int ONE_THRESHOLD = DEF_ONE_THRESH,
    parameter int MIN_HIGH      = DEF_MIN_HIGH,
    parameter int MAX_HIGH      = DEF_MAX_HIGH,
    parameter int RESET_TICKS   = DEF_RESET_TICKS
) (
    input  logic          clock_12mhz,
    input  logic          reset_n,
    xx6812_decoder_if.slave bus
);

    localparam logic [LOW_CW-1:0]  GAP      = LOW_CW'(RESET_TICKS);
    localparam logic [HIGH_CW-1:0] ONE_TH   = HIGH_CW'(ONE_THRESHOLD);
    localparam logic [HIGH_CW-1:0] MIN_H    = HIGH_CW'(MIN_HIGH);
    localparam logic [HIGH_CW-1:0] MAX_H    = HIGH_CW'(MAX_HIGH);
    localparam logic [BIT_CW-1:0]  LAST_BIT = BIT_CW'(PIXEL_W - 1);

    logic din_s, rise, fall;

    xx6812_decoder_din_synchronizer u_sync (
        .clk   (clock_12mhz),
        .rst_n (reset_n),
        .din   (bus.led_data_in),
        .din_s (din_s),
        .rise  (rise),
        .fall  (fall)
    );

    state_e                 state_q, state_d;
    logic [HIGH_CW-1:0]     high_cnt_q, high_cnt_d;
    logic [LOW_CW-1:0]      low_cnt_q, low_cnt_d;
    logic [BIT_CW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [PIXEL_W-1:0]     shift_q, shift_d;
    logic [PIXEL_W-1:0]     pixel_data_q, pixel_data_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [INDEX_WIDTH-1:0] pixel_index_q, pixel_index_d;
    logic                   bits_seen_q, bits_seen_d;
    logic                   pixel_valid_q, pixel_valid_d;
    logic                   frame_end_q, frame_end_d;
    logic                   protocol_error_q, protocol_error_d;

    logic [HIGH_CW-1:0] high_inc;
    logic [LOW_CW-1:0]  low_inc;
    logic [PIXEL_W-1:0] new_word;

    always_comb begin
        state_d          = state_q;
        high_cnt_d       = high_cnt_q;
        low_cnt_d        = low_cnt_q;
        bit_cnt_d        = bit_cnt_q;
        shift_d          = shift_q;
        pixel_data_d     = pixel_data_q;
        idx_d            = idx_q;
        pixel_index_d    = pixel_index_q;
        bits_seen_d      = bits_seen_q;
        pixel_valid_d    = 1'b0;
        frame_end_d      = 1'b0;
        protocol_error_d = 1'b0;

        high_inc = (high_cnt_q == '1) ? high_cnt_q : high_cnt_q + 1'b1;
        low_inc  = (low_cnt_q >= GAP) ? GAP : low_cnt_q + 1'b1;
        new_word = {shift_q[PIXEL_W-2:0], (high_cnt_q >= ONE_TH)};

        unique case (state_q)
            ST_RESYNC: begin
                if (din_s) begin
                    low_cnt_d = '0;
                end else begin
                    low_cnt_d = low_inc;
                    if (low_inc == GAP) begin
                        state_d     = ST_LOW;
                        bit_cnt_d   = '0;
                        idx_d       = '0;
                        bits_seen_d = 1'b0;
                    end
                end
            end

            ST_LOW: begin
                low_cnt_d = low_inc;
                // Gap fires once on the tick the counter saturates.
                if (low_inc == GAP && low_cnt_q != GAP) begin
                    frame_end_d      = bits_seen_q;
                    protocol_error_d = (bit_cnt_q != '0);
                    bit_cnt_d        = '0;
                    idx_d            = '0;
                    bits_seen_d      = 1'b0;
                end
                if (rise) begin
                    state_d    = ST_HIGH;
                    high_cnt_d = HIGH_CW'(1);
                end
            end

            ST_HIGH: begin
                if (fall) begin
                    if (high_cnt_q < MIN_H) begin
                        protocol_error_d = 1'b1;
                        state_d          = ST_RESYNC;
                        low_cnt_d        = '0;
                    end else begin
                        shift_d     = new_word;
                        bits_seen_d = 1'b1;
                        low_cnt_d   = '0;
                        state_d     = ST_LOW;
                        if (bit_cnt_q == LAST_BIT) begin
                            pixel_data_d  = new_word;
                            pixel_valid_d = 1'b1;
                            pixel_index_d = idx_q;
                            idx_d         = idx_q + 1'b1;
                            bit_cnt_d     = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end else begin
                    high_cnt_d = high_inc;
                    if (high_inc > MAX_H) begin
                        protocol_error_d = 1'b1;
                        state_d          = ST_RESYNC;
                        low_cnt_d        = '0;
                    end
                end
            end

            default: state_d = ST_RESYNC;
        endcase
    end

    always_ff @(posedge clock_12mhz) begin
        if (!reset_n) begin
            state_q          <= ST_RESYNC;
            high_cnt_q       <= '0;
            low_cnt_q        <= '0;
            bit_cnt_q        <= '0;
            shift_q          <= '0;
            pixel_data_q     <= '0;
            idx_q            <= '0;
            pixel_index_q    <= '0;
            bits_seen_q      <= 1'b0;
            pixel_valid_q    <= 1'b0;
            frame_end_q      <= 1'b0;
            protocol_error_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            high_cnt_q       <= high_cnt_d;
            low_cnt_q        <= low_cnt_d;
            bit_cnt_q        <= bit_cnt_d;
            shift_q          <= shift_d;
            pixel_data_q     <= pixel_data_d;
            idx_q            <= idx_d;
            pixel_index_q    <= pixel_index_d;
            bits_seen_q      <= bits_seen_d;
            pixel_valid_q    <= pixel_valid_d;
            frame_end_q      <= frame_end_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    assign bus.pixel_data     = pixel_data_q;
    assign bus.pixel_valid    = pixel_valid_q;
    assign bus.pixel_index    = pixel_index_q;
    assign bus.frame_end      = frame_end_q;
    assign bus.protocol_error = protocol_error_q;

endmodule

// File: tb/tb_xx6812_decoder.sv
// Scoreboard bench for xx6812_decoder: a frame-level model queues expected
// pixels and gap/error events; a monitor pops them as the decoders report.
module tb_xx6812_decoder;
    import xx6812_decoder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xx6812_decoder_if #(.INDEX_WIDTH(10)) bus  ();
    xx6812_decoder_if #(.INDEX_WIDTH(2))  bus2 ();
    assign bus2.led_data_in = bus.led_data_in;

    xx6812_decoder #(.INDEX_WIDTH(10)) dut  (.clock_12mhz(clk), .reset_n(rst_n), .bus(bus));
    xx6812_decoder #(.INDEX_WIDTH(2))  dut2 (.clock_12mhz(clk), .reset_n(rst_n), .bus(bus2));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { logic [23:0] data; int idx; } px_t;
    typedef struct { bit fe; bit pe; } ev_t;
    px_t px_q[$];
    ev_t ev_q[$];
    px_t px_e;
    ev_t ev_e;

    // Frame-level model state
    bit          synced = 1'b0;
    int          bits_px = 0;
    int          bits_gap = 0;
    int          idx = 0;
    logic [23:0] word = '0;
    logic [23:0] last_px = '0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic hold(logic v, int n);
        repeat (n) begin
            @(negedge clk);
            bus.led_data_in = v;
        end
    endtask

    task automatic send_bit(bit b, bit rnd);
        int hi, lo;
        if (rnd) begin
            hi = b ? int'($urandom_range(DEF_MAX_HIGH, DEF_ONE_THRESH))
                   : int'($urandom_range(DEF_ONE_THRESH - 1, DEF_MIN_HIGH));
            lo = int'($urandom_range(20, 1));
        end else begin
            hi = b ? T1H : T0H;
            lo = T_BIT - hi;
        end
        hold(1'b1, hi);
        if (synced) begin
            word = {word[22:0], b};
            bits_px++;
            bits_gap++;
            if (bits_px == 24) begin
                px_q.push_back('{word, idx});
                last_px = word;
                idx++;
                bits_px = 0;
            end
        end
        hold(1'b0, lo);
    endtask

    task automatic send_px(logic [23:0] w, bit rnd);
        for (int i = 23; i >= 0; i--) send_bit(w[i], rnd);
    endtask

    task automatic send_bits(int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(1, 0)), 1'b1);
    endtask

    task automatic gap();
        if (synced && bits_gap > 0) ev_q.push_back('{1'b1, bits_px != 0});
        synced   = 1'b1;
        bits_px  = 0;
        bits_gap = 0;
        idx      = 0;
        hold(1'b0, DEF_RESET_TICKS + 20);
    endtask

    // A bad high pulse while locked is an error and forces a resync.
    task automatic bad_pulse(int hi);
        if (synced) ev_q.push_back('{1'b0, 1'b1});
        synced = 1'b0;
        hold(1'b1, hi);
        hold(1'b0, 5);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        synced   = 1'b0;
        bits_px  = 0;
        bits_gap = 0;
        idx      = 0;
        chk("rst_pixel_data", 32'(bus.pixel_data), 32'h0);
        chk("rst_pixel_valid", 32'(bus.pixel_valid), 32'h0);
        chk("rst_pixel_index", 32'(bus.pixel_index), 32'h0);
        chk("rst_frame_end", 32'(bus.frame_end), 32'h0);
        chk("rst_protocol_error", 32'(bus.protocol_error), 32'h0);
        rst_n = 1'b1;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (bus.pixel_valid) begin
            if (px_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pixel: got data %0h idx %0d want none",
                         bus.pixel_data, bus.pixel_index);
            end else begin
                px_e = px_q.pop_front();
                chk("pixel_data", 32'(bus.pixel_data), 32'(px_e.data));
                chk("pixel_index", 32'(bus.pixel_index), 32'(px_e.idx % 1024));
                chk("w2_pixel_valid", 32'(bus2.pixel_valid), 32'h1);
                chk("w2_pixel_data", 32'(bus2.pixel_data), 32'(px_e.data));
                chk("w2_pixel_index", 32'(bus2.pixel_index), 32'(px_e.idx % 4));
            end
        end else if (bus2.pixel_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL w2_pixel_valid: got 1 want 0");
        end
        if (bus.frame_end || bus.protocol_error) begin
            if (ev_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got fe %0b pe %0b want none",
                         bus.frame_end, bus.protocol_error);
            end else begin
                ev_e = ev_q.pop_front();
                chk("frame_end", 32'(bus.frame_end), 32'(ev_e.fe));
                chk("protocol_error", 32'(bus.protocol_error), 32'(ev_e.pe));
            end
        end
    end

    initial begin
        bus.led_data_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pixel_data", 32'(bus.pixel_data), 32'h0);
        chk("reset_pixel_valid", 32'(bus.pixel_valid), 32'h0);
        chk("reset_pixel_index", 32'(bus.pixel_index), 32'h0);
        chk("reset_frame_end", 32'(bus.frame_end), 32'h0);
        chk("reset_protocol_error", 32'(bus.protocol_error), 32'h0);
        rst_n = 1'b1;

        gap();
        send_px(24'hA5F00F, 1'b0);
        gap();

        send_px(24'h000001, 1'b0);
        send_px(24'hFFFFFF, 1'b0);
        send_px(24'h123456, 1'b0);
        gap();

        send_bits(10);
        gap();
        send_px(24'($urandom), 1'b1);
        gap();

        send_bits(8);
        bad_pulse(1);
        send_bits(10);
        gap();
        send_px(24'h00FF00, 1'b0);
        gap();

        send_bits(5);
        bad_pulse(25);
        send_bits(4);
        gap();
        send_px(24'($urandom), 1'b1);
        gap();

        send_bits(12);
        pulse_reset();
        send_px(24'($urandom), 1'b1);
        gap();
        send_px(24'($urandom), 1'b1);
        gap();

        for (int f = 0; f < 6; f++) begin
            int n;
            n = (f == 0) ? 5 : int'($urandom_range(6, 1));
            for (int p = 0; p < n; p++) begin
                send_px(24'($urandom), 1'b1);
                if (p == 0 && f[0]) hold(1'b0, 500);
            end
            gap();
        end

        repeat (20) @(negedge clk);
        chk("pixels_outstanding", 32'(px_q.size()), 32'h0);
        chk("events_outstanding", 32'(ev_q.size()), 32'h0);
        chk("pixel_data_held", 32'(bus.pixel_data), 32'(last_px));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
